// File: rtl/ntt_input_packer_if.sv
// Stream bundle for the NTT input packer: scalar coefficient input side and
// 16-lane vector output side toward the radix-16 butterfly.
interface ntt_input_packer_if #(
  parameter int D_WIDTH = 64,
  parameter int LANES   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [D_WIDTH-1:0]       in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*D_WIDTH-1:0] out_vec;
  logic [4:0]               out_lanes;
  logic [7:0]               out_seq;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_lanes, out_seq
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_lanes, out_seq
  );
endinterface

// File: rtl/ntt_input_packer.sv
// Packs a natural-order coefficient stream into 16-lane vectors using two
// ping-pong banks; partial vectors (closed by in_last) are zero padded.
module ntt_input_packer #(
  parameter int D_WIDTH = 64,
  parameter int LANES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  ntt_input_packer_if.slave  bus
);

  logic [D_WIDTH-1:0]       bank_data  [2][LANES];
  logic [4:0]               bank_lanes [2];
  logic [7:0]               bank_seq   [2];
  logic [1:0]               full;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [3:0]               fill_cnt;
  logic [7:0]               seq_cnt;

  logic                     accept;
  logic                     close;
  logic                     consume;
  logic [LANES*D_WIDTH-1:0] vec;

  // A closing bank is never the one being consumed: wr_bank is empty, rd_bank full.
  always_comb begin
    accept  = bus.in_valid && !full[wr_bank];
    close   = accept && ((fill_cnt == 4'd15) || bus.in_last);
    consume = full[rd_bank] && bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      fill_cnt <= '0;
      seq_cnt  <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        bank_lanes[b] <= '0;
        bank_seq[b]   <= '0;
        for (int unsigned k = 0; k < LANES; k++) begin
          bank_data[b][k] <= '0;
        end
      end
    end else begin
      if (accept) begin
        bank_data[wr_bank][fill_cnt] <= bus.in_data;
        if (close) begin
          full[wr_bank]       <= 1'b1;
          bank_lanes[wr_bank] <= {1'b0, fill_cnt} + 5'd1;
          bank_seq[wr_bank]   <= seq_cnt;
          seq_cnt             <= seq_cnt + 8'd1;
          fill_cnt            <= '0;
          wr_bank             <= ~wr_bank;
        end else begin
          fill_cnt <= fill_cnt + 4'd1;
        end
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Lanes beyond the closed count are masked, so leftovers from an earlier,
  // longer vector in the same bank never reach the butterfly.
  always_comb begin
    vec = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (full[rd_bank] && (5'(k) < bank_lanes[rd_bank])) begin
        vec[k*D_WIDTH +: D_WIDTH] = bank_data[rd_bank][k];
      end
    end
  end

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_vec   = vec;
  assign bus.out_lanes = bank_lanes[rd_bank];
  assign bus.out_seq   = bank_seq[rd_bank];

endmodule

// File: tb/tb_ntt_input_packer.sv
// Scoreboard bench for ntt_input_packer: a queue-based reference model builds
// expected vectors on each accept; a negedge monitor checks what the DUT presents.
module tb_ntt_input_packer;
  localparam int DW = 64;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_input_packer_if #(.D_WIDTH(DW), .LANES(NL)) bus ();
  ntt_input_packer #(.D_WIDTH(DW), .LANES(NL)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [NL*DW-1:0] vec;
    int               lanes;
    int               seq;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] cur[$];
  int            seq_m   = 0;
  int            acc_cnt = 0;
  int            total   = 0;
  int            bad     = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NL*DW-1:0] got, input logic [NL*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      for (int k = 0; k < NL; k++) begin
        if (got[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s lane %0d: got %0h expected %0h", name, k, got[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Reference: collect coefficients; a vector is emitted at 16 or on last.
  function automatic void model_accept(input logic [DW-1:0] d, input logic last);
    exp_t e;
    cur.push_back(d);
    if (last || cur.size() == NL) begin
      e.vec = '0;
      for (int k = 0; k < cur.size(); k++) e.vec[k*DW +: DW] = cur[k];
      e.lanes = cur.size();
      e.seq   = seq_m;
      sb.push_back(e);
      seq_m = (seq_m + 1) % 256;
      cur.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
      if (bus.out_valid && sb.size() > 0) begin
        chk_vec("out_vec", bus.out_vec, sb[0].vec);
        chk("out_lanes", 64'(bus.out_lanes), 64'(sb[0].lanes));
        chk("out_seq", 64'(bus.out_seq), 64'(sb[0].seq));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l,
                     input logic ordy, input logic r);
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    @(negedge clk);
    #1;
    if (rst) begin
      sb.delete();
      cur.delete();
      seq_m = 0;
    end else if (bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      model_accept(d, l);
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    acc_cnt = 0;
  endtask

  initial begin
    logic [DW-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_vec("reset out_vec", bus.out_vec, '0);
    chk("reset out_lanes", 64'(bus.out_lanes), 64'd0);
    chk("reset out_seq", 64'(bus.out_seq), 64'd0);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);

    // Full vector 0..15, then a 3-lane padded vector.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i), i == 15, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(7 + i), i == 2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Backpressure: both banks fill, then drain three vectors in order.
    do_reset();
    for (int i = 0; i < 45; i++) cyc(acc_cnt < 40, DW'(acc_cnt), acc_cnt == 39, 1'b0, 1'b0);
    chk("stalled accepts", 64'(acc_cnt), 64'd32);
    for (int i = 0; i < 40 && acc_cnt < 40; i++) cyc(1'b1, DW'(acc_cnt), acc_cnt == 39, 1'b1, 1'b0);
    chk("resumed accepts", 64'(acc_cnt), 64'd40);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a partial vector.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(100 + i), 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("post-rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("post-rst out_seq", 64'(bus.out_seq), 64'd0);
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      cyc(1'b1, d, i == 15, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      d = {$urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) != 0, 1'b0);
    end

    // Continuous stream: one accept per cycle, sequence wraps past 255.
    do_reset();
    for (int i = 0; i < 4128; i++) begin
      d = {$urandom, $urandom};
      cyc(1'b1, d, 1'b0, 1'b1, 1'b0);
    end
    chk("stream accepts", 64'(acc_cnt), 64'd4128);

    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
